// File: rtl/bcd_converter_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per cycle) with
// overflow saturate/wrap and leading-zero blanking; valid/ready on both sides.
module bcd_converter_seq #(
  parameter int BIN_W    = 8,
  parameter int DIGITS   = 3,
  parameter int SATURATE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic [DIGITS-1:0]     out_blank,
  output logic                  out_ovf,
  output logic                  busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} ^ DIGITS'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_nxt;
  logic [BIN_W-1:0]   bin_q;
  logic [BCD_W-1:0]   acc_q, adj, acc_nxt, pres_bcd;
  logic [DIGITS-1:0]  pres_blank;
  logic               ovf_q, ovf_nxt, last_step, hi_zero;
  logic [CNT_W-1:0]   cnt_q;

  assign in_ready  = (state == IDLE);
  assign busy      = (state == SHIFT);
  assign out_valid = (state == DONE);
  assign last_step = (cnt_q == CNT_W'(1));

  always_comb begin
    adj = acc_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc_q[4*d +: 4] >= 4'd5) adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
    end
    acc_nxt = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
    // Any carry out of the top digit means the value reached 10^DIGITS.
    ovf_nxt = ovf_q | adj[BCD_W-1];
    if (ovf_nxt && (SATURATE != 0)) pres_bcd = {DIGITS{4'h9}};
    else                            pres_bcd = acc_nxt;
    pres_blank = '0;
    hi_zero    = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      hi_zero       = hi_zero & (pres_bcd[4*k +: 4] == 4'd0);
      pres_blank[k] = hi_zero;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = SHIFT;
      SHIFT:   if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q     <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      out_bcd   <= '0;
      out_blank <= BLANK_RST;
      out_ovf   <= 1'b0;
    end else if (clr) begin
      cnt_q <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          bin_q <= in_bin;
          acc_q <= '0;
          ovf_q <= 1'b0;
          cnt_q <= CNT_W'(BIN_W);
        end
        SHIFT: begin
          bin_q <= bin_q << 1;
          acc_q <= acc_nxt;
          ovf_q <= ovf_nxt;
          cnt_q <= cnt_q - CNT_W'(1);
          // Result registers change only here, so they hold between results.
          if (last_step) begin
            out_bcd   <= pres_bcd;
            out_blank <= pres_blank;
            out_ovf   <= ovf_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_converter_seq.sv
// Randomized and directed bench for bcd_converter_seq: three instances
// (3 digits saturate, 2 digits saturate, 2 digits wrap) run in lockstep.
module tb_bcd_converter_seq;

  logic       clk = 1'b0;
  logic       rst_n, clr, in_valid, out_ready;
  logic [7:0] in_bin;

  logic        rdy_a, vld_a, ovf_a, busy_a;
  logic [11:0] bcd_a;
  logic [2:0]  blank_a;
  logic        rdy_b, vld_b, ovf_b, busy_b;
  logic [7:0]  bcd_b;
  logic [1:0]  blank_b;
  logic        rdy_c, vld_c, ovf_c, busy_c;
  logic [7:0]  bcd_c;
  logic [1:0]  blank_c;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int acc_times[$];

  always #5 clk = ~clk;

  bcd_converter_seq #(.BIN_W(8), .DIGITS(3), .SATURATE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy_a),
    .in_bin(in_bin), .out_valid(vld_a), .out_ready(out_ready), .out_bcd(bcd_a),
    .out_blank(blank_a), .out_ovf(ovf_a), .busy(busy_a));

  bcd_converter_seq #(.BIN_W(8), .DIGITS(2), .SATURATE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy_b),
    .in_bin(in_bin), .out_valid(vld_b), .out_ready(out_ready), .out_bcd(bcd_b),
    .out_blank(blank_b), .out_ovf(ovf_b), .busy(busy_b));

  bcd_converter_seq #(.BIN_W(8), .DIGITS(2), .SATURATE(0)) u_c (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy_c),
    .in_bin(in_bin), .out_valid(vld_c), .out_ready(out_ready), .out_bcd(bcd_c),
    .out_blank(blank_c), .out_ovf(ovf_c), .busy(busy_c));

  always @(posedge clk) begin
    cyc++;
    if (rst_n && !clr && in_valid && rdy_a) acc_times.push_back(cyc);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Decimal reference: clamp or wrap at 10^dg, then split into digits.
  function automatic void ref_conv(input int x, input int dg, input bit sat,
                                   output longint bcd, output longint blank, output bit ovf);
    longint lim, v, p;
    lim = 1;
    for (int i = 0; i < dg; i++) lim = lim * 10;
    ovf = (x >= lim);
    v   = ovf ? (sat ? lim - 1 : x % lim) : x;
    bcd = 0;
    p   = v;
    for (int i = 0; i < dg; i++) begin
      bcd = bcd | ((p % 10) << (4 * i));
      p   = p / 10;
    end
    blank = 0;
    p     = 10;
    for (int k = 1; k < dg; k++) begin
      if (v < p) blank = blank | (longint'(1) << k);
      p = p * 10;
    end
  endfunction

  task automatic check_result(input int x);
    longint bcd, blank;
    bit ovf;
    ref_conv(x, 3, 1'b1, bcd, blank, ovf);
    check($sformatf("a_bcd(%0d)", x), 64'(bcd_a), bcd);
    check($sformatf("a_blank(%0d)", x), 64'(blank_a), blank);
    check($sformatf("a_ovf(%0d)", x), 64'(ovf_a), 64'(ovf));
    ref_conv(x, 2, 1'b1, bcd, blank, ovf);
    check($sformatf("b_bcd(%0d)", x), 64'(bcd_b), bcd);
    check($sformatf("b_blank(%0d)", x), 64'(blank_b), blank);
    check($sformatf("b_ovf(%0d)", x), 64'(ovf_b), 64'(ovf));
    ref_conv(x, 2, 1'b0, bcd, blank, ovf);
    check($sformatf("c_bcd(%0d)", x), 64'(bcd_c), bcd);
    check($sformatf("c_blank(%0d)", x), 64'(blank_c), blank);
    check($sformatf("c_ovf(%0d)", x), 64'(ovf_c), 64'(ovf));
    check("bc_valid", 64'({vld_b, vld_c}), 64'd3);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!vld_a && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!vld_a) check("valid_timeout", 64'(vld_a), 64'd1);
  endtask

  task automatic convert(input int x, input int stall);
    int n;
    @(negedge clk);
    in_bin    = 8'(x);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    check("in_ready_idle", 64'(rdy_a), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_bin   = 8'($urandom);
    wait_valid(n);
    check($sformatf("latency(%0d)", x), 64'(n + 1), 64'd9);
    check_result(x);
    repeat (stall) begin
      @(negedge clk);
      check("stall_valid", 64'(vld_a), 64'd1);
      check("stall_in_ready", 64'(rdy_a), 64'd0);
      check_result(x);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("consumed", 64'(vld_a), 64'd0);
    check("idle_again", 64'(rdy_a), 64'd1);
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", 64'({rdy_a, rdy_b, rdy_c}), 64'd7);
    check("rst_out_valid", 64'({vld_a, vld_b, vld_c}), 64'd0);
    check("rst_busy", 64'({busy_a, busy_b, busy_c}), 64'd0);
    check("rst_bcd_a", 64'(bcd_a), 64'h000);
    check("rst_bcd_b", 64'(bcd_b), 64'h00);
    check("rst_blank_a", 64'(blank_a), 64'b110);
    check("rst_blank_b", 64'(blank_b), 64'b10);
    check("rst_ovf", 64'({ovf_a, ovf_b, ovf_c}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, na;
    int dir[9] = '{0, 99, 100, 200, 213, 255, 7, 9, 10};
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_bin = '0;
    repeat (3) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;

    foreach (dir[i]) convert(dir[i], 0);
    convert(123, 20);

    // Back-to-back with out_ready tied high.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_bin = 8'd255;
    na = acc_times.size();
    n = 0;
    while (acc_times.size() <= na && n < 40) begin @(negedge clk); n++; end
    in_bin = 8'd7;
    wait_valid(n);
    check_result(255);
    n = 0;
    while (acc_times.size() <= na + 1 && n < 40) begin @(negedge clk); n++; end
    in_valid = 1'b0;
    wait_valid(n);
    check_result(7);
    if (acc_times.size() >= na + 2)
      check("accept_spacing", 64'(acc_times[na+1] - acc_times[na]), 64'd10);
    else
      check("accept_count", 64'(acc_times.size() - na), 64'd2);
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the middle of SHIFT, then restart on the first edge.
    in_bin = 8'd173; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_before_rst", 64'(busy_a), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1; in_bin = 8'd42; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check("accept_after_rst", 64'(busy_a), 64'd1);
    wait_valid(n);
    check("latency_after_rst", 64'(n + 1), 64'd9);
    check_result(42);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // clr during SHIFT, with in_valid and out_ready also high.
    in_bin = 8'd200; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    clr = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("clr_shift_valid", 64'(vld_a), 64'd0);
    check("clr_shift_ready", 64'(rdy_a), 64'd1);
    check("clr_shift_busy", 64'(busy_a), 64'd0);
    check("clr_hold_bcd", 64'(bcd_a), 64'h042);

    // clr while a result is waiting.
    in_bin = 8'd5; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(n);
    check_result(5);
    clr = 1'b1; in_valid = 1'b1; in_bin = 8'd77;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    check("clr_done_valid", 64'(vld_a), 64'd0);
    check("clr_done_ready", 64'(rdy_a), 64'd1);
    check("clr_done_hold", 64'(bcd_a), 64'h005);

    for (int i = 0; i < 25; i++) convert(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_converter_seq.md
BCD_CONVERTER_SEQ -- requirements
Module: bcd_converter_seq

Interface
REQ-001 SHALL have parameter BIN_W, default 8: binary input width, legal range 4..32.
REQ-002 SHALL have parameter DIGITS, default 3: number of BCD output digits, legal range 1..10.
REQ-003 SHALL have parameter SATURATE, default 1: overflow handling; 1 = clamp to all nines, 0 = wrap modulo 10^DIGITS.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port clr, input, 1 bit: synchronous abort; returns the block to IDLE.
REQ-007 SHALL have port in_valid, input, 1 bit: in_bin is valid.
REQ-008 SHALL have port in_ready, output, 1 bit: the block can accept a value.
REQ-009 SHALL have port in_bin, input, BIN_W bits: unsigned binary value to convert.
REQ-010 SHALL have port out_valid, output, 1 bit: result is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL have port out_bcd, output, 4*DIGITS bits: digit k occupies bits [4k+3:4k]; digit 0 is the ones digit.
REQ-013 SHALL have port out_blank, output, DIGITS bits: bit k set = digit k is a leading zero.
REQ-014 SHALL have port out_ovf, output, 1 bit: in_bin exceeded 10^DIGITS-1.
REQ-015 SHALL have port busy, output, 1 bit: a conversion is in progress (SHIFT state).

Function
REQ-016 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-017 SHALL drive in_ready=1 only in IDLE.
REQ-018 SHALL, in IDLE, on in_valid&&in_ready: latch in_bin, clear the BCD accumulator and overflow flag, load the shift counter with BIN_W, and go to SHIFT.
REQ-019 SHALL, in each SHIFT cycle, perform one double-dabble step: add 3 to every digit >=5, then shift {accumulator, binary} left by 1, shifting in the binary MSB.
REQ-020 SHALL set the sticky overflow flag when a 1 is shifted out of the top digit during the step in REQ-019.
REQ-021 SHALL leave SHIFT for DONE after exactly BIN_W SHIFT cycles.
REQ-022 SHALL give out_valid=1 starting BIN_W+1 cycles after the accepting edge.
REQ-023 SHALL give a throughput of one conversion per BIN_W+2 cycles when out_ready is tied high.
REQ-024 SHALL, in DONE, hold out_valid=1 and keep out_bcd, out_blank and out_ovf stable until out_valid&&out_ready, then go to IDLE on that edge.
REQ-025 SHALL accept no new input in DONE (in_ready=0) even if out_ready is high.
REQ-026 SHALL, when overflow is set and SATURATE=1, present out_bcd as all digits = 9.
REQ-027 SHALL, when overflow is set and SATURATE=0, present out_bcd as the value modulo 10^DIGITS.
REQ-028 SHALL assert out_ovf whenever overflow is set, in either mode.
REQ-029 SHALL set out_blank[k] for k>=1 iff digit k and all higher digits are 0.
REQ-030 SHALL never set out_blank[0], so an input of 0 displays as "0".
REQ-031 SHALL compute out_blank from the presented (post-saturation) digits.
REQ-032 SHALL return to IDLE on the next edge when clr=1, from any state.
REQ-033 SHALL drive out_valid=0 in the cycle after clr, with no result emitted.
REQ-034 SHALL give clr priority over in_valid and out_ready in the same cycle.
REQ-035 SHALL keep out_bcd, out_blank and out_ovf undefined-free when out_valid=0: they hold the last result, or zero after reset.
REQ-036 SHALL treat an in_bin change during SHIFT as having no effect.

Reset
REQ-037 SHALL, while rst_n=0, asynchronously force state=IDLE, in_ready=1, out_valid=0, busy=0, out_bcd=0, out_blank=all-ones except bit 0, out_ovf=0, and clear the counter and all internal registers.
REQ-038 SHALL, when rst_n deasserts mid-conversion, discard the conversion with no result emitted.
REQ-039 SHALL accept input on the first rising edge after rst_n deasserts, if in_valid=1.

Verification
REQ-040 SHALL cover: BIN_W=8, DIGITS=3, in_bin=0 -> out_bcd=0x000, out_blank=3'b110, out_ovf=0, out_valid at cycle 9 after accept.
REQ-041 SHALL cover: BIN_W=8, DIGITS=3, in_bin=255 then 7 back-to-back with out_ready=1 -> 0x255/blank 000, then 0x007/blank 110, accepted 10 cycles apart.
REQ-042 SHALL cover: BIN_W=8, DIGITS=2, SATURATE=1, in_bin=99 -> 0x99 ovf=0; in_bin=100 -> 0x99 ovf=1; in_bin=200 -> 0x99 ovf=1.
REQ-043 SHALL cover: BIN_W=8, DIGITS=2, SATURATE=0, in_bin=100 -> 0x00 ovf=1, out_blank=2'b10; in_bin=213 -> 0x13 ovf=1.
REQ-044 SHALL cover: out_ready=0 for 20 cycles after out_valid -> outputs stable, in_ready=0 throughout; the result is consumed on the first out_ready=1 edge.
REQ-045 SHALL cover: rst_n pulsed low at SHIFT cycle 4 of in_bin=173 -> immediate reset values, no out_valid; the next conversion of 42 -> 0x042.
